// File: rtl/monolith_axil_pkg.sv
// Shared types, register offsets and field helpers for the Monolith AXI4-Lite front-end.
package monolith_axil_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t       M31_P    = 31'h7FFF_FFFF;
    localparam logic [3:0] REG_IN1  = 4'h0;
    localparam logic [3:0] REG_IN2  = 4'h4;
    localparam logic [3:0] REG_OUT  = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;
    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [1:0] {
        RegIn1  = REG_IN1[3:2],
        RegIn2  = REG_IN2[3:2],
        RegOut  = REG_OUT[3:2],
        RegCtrl = REG_CTRL[3:2]
    } reg_idx_e;

    // Byte-enable merge into a 31-bit field element, folding p onto 0.
    function automatic m31_t m31_merge(m31_t old_val, m31_t data, logic [3:0] strb);
        m31_t res;
        res[7:0]   = strb[0] ? data[7:0]   : old_val[7:0];
        res[15:8]  = strb[1] ? data[15:8]  : old_val[15:8];
        res[23:16] = strb[2] ? data[23:16] : old_val[23:16];
        res[30:24] = strb[3] ? data[30:24] : old_val[30:24];
        return (res == M31_P) ? '0 : res;
    endfunction

endpackage

// File: rtl/monolith_axil_if.sv
// AXI4-Lite channel handshakes: captures AW and W independently, issues one write
// at a time, and returns registered read data for a single outstanding read.
module monolith_axil_if
    import monolith_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ADDR_W-1:0]     araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  wr_en_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic [DATA_W/8-1:0]   wr_strb_o,
    output logic                  rd_en_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [DATA_W-1:0]     rd_data_i
);

    logic                live_q;
    logic                aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q, rdata_q;
    logic [DATA_W/8-1:0] w_strb_q;

    // live_q keeps every ready low while reset is asserted.
    assign awready_o = live_q && !aw_held_q;
    assign wready_o  = live_q && !w_held_q;
    assign arready_o = live_q && !rvalid_q;
    assign bvalid_o  = bvalid_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;

    assign wr_en_o   = aw_held_q && w_held_q && !bvalid_q;
    assign wr_addr_o = aw_addr_q;
    assign wr_data_o = w_data_q;
    assign wr_strb_o = w_strb_q;
    assign rd_en_o   = arvalid_i && arready_o;
    assign rd_addr_o = araddr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata_q   <= '0;
        end else begin
            live_q <= 1'b1;
            if (awvalid_i && awready_o) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= awaddr_i;
            end
            if (wvalid_i && wready_o) begin
                w_held_q <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
            if (wr_en_o) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
            end else if (bvalid_q && bready_i) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en_o) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_i;
            end else if (rvalid_q && rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/monolith_axil_slave.sv
// AXI4-Lite register front-end for the Monolith M31 hash core (operands, go, result/valid).
// Optional irq output and CTRL bit1 enable when MONOLITH_AXIL_IRQ_EN is defined.
module monolith_axil_slave
    import monolith_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                core_start,
    output logic [30:0]         core_in1,
    output logic [30:0]         core_in2,
    input  logic                core_done,
    input  logic [30:0]         core_out
`ifdef MONOLITH_AXIL_IRQ_EN
    , output logic              irq
`endif
);

    logic                wr_en, rd_en;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [DATA_W-1:0]   wr_data, rd_data;
    logic [DATA_W/8-1:0] wr_strb;

    m31_t in1_q, in1_d, in2_q, in2_d, result_q, result_d;
    m31_t cin1_q, cin1_d, cin2_q, cin2_d;
    logic go_q, go_new, valid_q, valid_d, busy_q, busy_d, pend_q, pend_d;
    logic start_q, start_d, launch;
    logic ctrl_bit1;
`ifdef MONOLITH_AXIL_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq       = irq_q;
    assign ctrl_bit1 = irq_en_q;
`else
    assign ctrl_bit1 = 1'b0;
`endif

    logic unused;
    assign unused = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], rd_addr[1:0], wr_data[31]};

    assign s_axi_bresp = AXI_OKAY;
    assign s_axi_rresp = AXI_OKAY;
    assign core_start  = start_q;
    assign core_in1    = cin1_q;
    assign core_in2    = cin2_q;

    monolith_axil_if #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_if (
        .clk_i     (aclk),
        .rst_i     (areset),
        .awaddr_i  (s_axi_awaddr),
        .awvalid_i (s_axi_awvalid),
        .awready_o (s_axi_awready),
        .wdata_i   (s_axi_wdata),
        .wstrb_i   (s_axi_wstrb),
        .wvalid_i  (s_axi_wvalid),
        .wready_o  (s_axi_wready),
        .bvalid_o  (s_axi_bvalid),
        .bready_i  (s_axi_bready),
        .araddr_i  (s_axi_araddr),
        .arvalid_i (s_axi_arvalid),
        .arready_o (s_axi_arready),
        .rdata_o   (s_axi_rdata),
        .rvalid_o  (s_axi_rvalid),
        .rready_i  (s_axi_rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    always_comb begin
        rd_data = '0;
        case (reg_idx_e'(rd_addr[3:2]))
            RegIn1:  rd_data = {1'b0, in1_q};
            RegIn2:  rd_data = {1'b0, in2_q};
            RegOut:  rd_data = {result_q, valid_q};
            RegCtrl: rd_data = {30'b0, ctrl_bit1, go_q};
        endcase
    end

    // Completion is applied before any CTRL write in the same cycle.
    always_comb begin
        in1_d    = in1_q;
        in2_d    = in2_q;
        go_new   = go_q;
        result_d = result_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        pend_d   = pend_q;
        cin1_d   = cin1_q;
        cin2_d   = cin2_q;
        start_d  = 1'b0;
        launch   = 1'b0;
`ifdef MONOLITH_AXIL_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (core_done && busy_q) begin
            result_d = core_out;
            busy_d   = 1'b0;
            valid_d  = go_q;
        end
        if (wr_en) begin
            case (reg_idx_e'(wr_addr[3:2]))
                RegIn1:  in1_d = m31_merge(in1_q, wr_data[30:0], wr_strb);
                RegIn2:  in2_d = m31_merge(in2_q, wr_data[30:0], wr_strb);
                RegCtrl: begin
                    if (wr_strb[0]) begin
                        go_new = wr_data[0];
`ifdef MONOLITH_AXIL_IRQ_EN
                        irq_en_d = wr_data[1];
`endif
                    end
                end
                default: ;
            endcase
        end
        if (!go_new) begin
            valid_d = 1'b0;
            pend_d  = 1'b0;
        end else if (!go_q) begin
            if (busy_d) pend_d = 1'b1;
            else        launch = 1'b1;
        end else if (pend_q && !busy_d) begin
            launch = 1'b1;
        end
        if (launch) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            pend_d  = 1'b0;
            cin1_d  = in1_q;
            cin2_d  = in2_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            in1_q    <= '0;
            in2_q    <= '0;
            go_q     <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            cin1_q   <= '0;
            cin2_q   <= '0;
`ifdef MONOLITH_AXIL_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            go_q     <= go_new;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            start_q  <= start_d;
            cin1_q   <= cin1_d;
            cin2_q   <= cin2_d;
`ifdef MONOLITH_AXIL_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= valid_d & go_new & irq_en_d;
`endif
        end
    end

endmodule

// File: tb/tb_monolith_axil_slave.sv
// Self-checking bench for monolith_axil_slave with a fixed-latency hash core model.
module tb_monolith_axil_slave;
    import monolith_axil_pkg::*;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        core_start, core_done;
    logic [30:0] core_in1, core_in2, core_out;
`ifdef MONOLITH_AXIL_IRQ_EN
    logic        irq;
`endif

    int n_pass = 0, n_total = 0;
    int cnt = 0, starts = 0, cyc = 0, last_done = -1, last_start = -1;
    logic [30:0] cin1_seen = '0, cin2_seen = '0;

    monolith_axil_slave dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .core_start    (core_start),
        .core_in1      (core_in1),
        .core_in2      (core_in2),
        .core_done     (core_done),
        .core_out      (core_out)
`ifdef MONOLITH_AXIL_IRQ_EN
        , .irq         (irq)
`endif
    );

    always #5 aclk = ~aclk;

    // Core model: not reset by areset, so a hash in flight still reports done later.
    assign core_out  = 31'h0123_4567;
    assign core_done = (cnt == 1);
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (core_start) begin
            cnt        <= 20;
            starts     <= starts + 1;
            cin1_seen  <= core_in1;
            cin2_seen  <= core_in2;
            last_start <= cyc;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
        if (core_done) last_done <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: handshake timed out, expected completion within bound", name);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic aw_fire, w_fire;
        @(negedge aclk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge aclk);
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) begin
            timeout_fail("write_addr_data");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        for (int j = 0; j < 20 && !bvalid; j++) @(negedge aclk);
        if (!bvalid) timeout_fail("write_resp");
        else begin
            bready = 1'b1;
            @(negedge aclk);
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        data = '0;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1;
        for (int i = 0; i < 20 && !arready; i++) @(negedge aclk);
        if (!arready) begin
            timeout_fail("read_addr");
            arvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        arvalid = 1'b0;
        for (int j = 0; j < 20 && !rvalid; j++) @(negedge aclk);
        if (!rvalid) begin
            timeout_fail("read_data");
            return;
        end
        data = rdata;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] d;
    int          bv_cycles;

    initial begin
        vecs[0] = '{"in1_plain",     REG_IN1,  32'h0000_0036, 4'hF, 32'h0000_0036};
        vecs[1] = '{"in2_p_to_zero", REG_IN2,  32'h7FFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[2] = '{"in1_strb_0011", REG_IN1,  32'hFFFF_FFFF, 4'h3, 32'h0000_FFFF};
        vecs[3] = '{"in1_strb_1100", REG_IN1,  32'h1234_5678, 4'hC, 32'h1234_FFFF};
        vecs[4] = '{"in2_bit31_drop",REG_IN2,  32'h8000_0005, 4'hF, 32'h0000_0005};
        vecs[5] = '{"in2_p_minus_1", REG_IN2,  32'hFFFF_FFFE, 4'hF, 32'h7FFF_FFFE};
        vecs[6] = '{"in2_strb_none", REG_IN2,  32'h0000_0000, 4'h0, 32'h7FFF_FFFE};
        vecs[7] = '{"in2_all_ones",  REG_IN2,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[8] = '{"out_ro",        REG_OUT,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
        vecs[9] = '{"ctrl_hi_bits",  REG_CTRL, 32'hFFFF_FFFE, 4'hF, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_arready", {31'b0, arready}, 32'h0);
        check("rst_bvalid",  {31'b0, bvalid},  32'h0);
        check("rst_rvalid",  {31'b0, rvalid},  32'h0);
        check("rst_start",   {31'b0, core_start}, 32'h0);
        areset = 1'b0;
        axi_read(REG_IN1, d);  check("rst_in1", d, 32'h0);
        axi_read(REG_IN2, d);  check("rst_in2", d, 32'h0);
        axi_read(REG_OUT, d);  check("rst_out", d, 32'h0);
        axi_read(REG_CTRL, d); check("rst_ctrl", d, 32'h0);

        foreach (vecs[i]) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // AW one cycle ahead of W, response held off for 5 cycles
        @(negedge aclk);
        awaddr = REG_IN2; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        check("aw_held_ready", {31'b0, awready}, 32'h0);
        wdata = 32'h0000_0ABC; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        bv_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            if (bvalid) bv_cycles++;
        end
        check("bvalid_held", bv_cycles, 5);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("bvalid_drop", {31'b0, bvalid}, 32'h0);
        repeat (2) @(negedge aclk);
        check("no_second_b", {31'b0, bvalid}, 32'h0);
        axi_read(REG_IN2, d); check("aw_first_in2", d, 32'h0000_0ABC);

        // First hash
        axi_write(REG_IN1, 32'd54, 4'hF);
        axi_write(REG_IN2, 32'd0, 4'hF);
        check("no_start_yet", starts, 0);
        axi_write(REG_CTRL, 32'd1, 4'hF);
        for (int i = 0; i < 10 && starts == 0; i++) @(negedge aclk);
        check("start_1", starts, 1);
        check("cin1_1", {1'b0, cin1_seen}, 32'd54);
        check("cin2_1", {1'b0, cin2_seen}, 32'd0);
        axi_read(REG_OUT, d); check("out_busy", d, 32'h0);
        repeat (25) @(negedge aclk);
        axi_read(REG_OUT, d);  check("out_done_1", d, 32'h0246_8ACF);
        axi_read(REG_CTRL, d); check("ctrl_go_1", d, 32'h1);
        check("single_start", starts, 1);

        // Clear go: valid drops, result kept
        axi_write(REG_CTRL, 32'd0, 4'hF);
        axi_read(REG_OUT, d);  check("out_go0", d, 32'h0246_8ACE);
        axi_read(REG_CTRL, d); check("ctrl_go0", d, 32'h0);

        // Restart
        axi_write(REG_CTRL, 32'd1, 4'hF);
        repeat (25) @(negedge aclk);
        check("start_2", starts, 2);
        axi_read(REG_OUT, d); check("out_done_2", d, 32'h0246_8ACF);
        axi_write(REG_CTRL, 32'd1, 4'hF);
        repeat (3) @(negedge aclk);
        check("go_1_again_no_restart", starts, 2);

        // Clear and re-set go mid-hash: start deferred to the cycle after done
        axi_write(REG_CTRL, 32'd0, 4'hF);
        axi_write(REG_CTRL, 32'd1, 4'hF);
        check("start_3", starts, 3);
        axi_write(REG_IN1, 32'd7, 4'hF);
        check("core_in1_stable", {1'b0, core_in1}, 32'd54);
        axi_write(REG_CTRL, 32'd0, 4'hF);
        axi_write(REG_CTRL, 32'd1, 4'hF);
        check("deferred_not_yet", starts, 3);
        for (int i = 0; i < 30 && starts == 3; i++) @(negedge aclk);
        check("start_4", starts, 4);
        check("deferred_timing", last_start - last_done, 1);
        check("cin1_4", {1'b0, cin1_seen}, 32'd7);
        repeat (25) @(negedge aclk);
        axi_read(REG_OUT, d); check("out_done_4", d, 32'h0246_8ACF);

        // Reset while busy, then a stray done from the still-running core
        axi_write(REG_CTRL, 32'd0, 4'hF);
        axi_write(REG_CTRL, 32'd1, 4'hF);
        check("start_5", starts, 5);
        repeat (5) @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (30) @(negedge aclk);
        check("no_start_after_rst", starts, 5);
        axi_read(REG_IN1, d);  check("rst2_in1", d, 32'h0);
        axi_read(REG_IN2, d);  check("rst2_in2", d, 32'h0);
        axi_read(REG_OUT, d);  check("rst2_out", d, 32'h0);
        axi_read(REG_CTRL, d); check("rst2_ctrl", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
